// File: rtl/rate_mod_counter_if.sv
// Switch inputs and counter outputs of rate_mod_counter, bundled for the top-level port list.
// The master side drives the switches and observes the count; the slave side is the counter.
interface rate_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             SW17;
  logic             SW16;
  logic             SW1;
  logic             SW2;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             wrap;

  modport master (
    output SW17, SW16, SW1, SW2,
    input  count, tick, wrap
  );

  modport slave (
    input  SW17, SW16, SW1, SW2,
    output count, tick, wrap
  );
endinterface

// File: rtl/rate_mod_counter.sv
// Single-domain modulo up/down counter that advances on a prescaler tick at one of four rates.
// The tick is only ever used as an enable; count, tick and wrap are all registered.
module rate_mod_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 7,
  parameter int PRESC_W   = 29,
  parameter int DIV0      = 25000000,
  parameter int DIV1      = 50000000,
  parameter int DIV2      = 100000000,
  parameter int DIV3      = 300000000
) (
  input  logic               PIN_Y2,
  input  logic               SW0,
  rate_mod_counter_if.slave  bus
);

  localparam logic [PRESC_W-1:0] DIV0_M1 = PRESC_W'(DIV0 - 1);
  localparam logic [PRESC_W-1:0] DIV1_M1 = PRESC_W'(DIV1 - 1);
  localparam logic [PRESC_W-1:0] DIV2_M1 = PRESC_W'(DIV2 - 1);
  localparam logic [PRESC_W-1:0] DIV3_M1 = PRESC_W'(DIV3 - 1);
  localparam logic [WIDTH-1:0]   MAX_C   = WIDTH'(MAX_COUNT);

  logic [1:0]         sel_r;
  logic [PRESC_W-1:0] presc_r;
  logic [WIDTH-1:0]   count_r;
  logic               tick_r;
  logic               wrap_r;

  logic [1:0]         sel_in_s;
  logic               sel_chg_s;
  logic [PRESC_W-1:0] div_m1_s;
  logic               tick_s;
  logic [PRESC_W-1:0] presc_nxt_s;
  logic [WIDTH-1:0]   count_nxt_s;
  logic               wrap_nxt_s;

  assign sel_in_s  = {bus.SW17, bus.SW16};
  assign sel_chg_s = (sel_in_s != sel_r);

  // Terminal prescaler value for the currently registered rate.
  always_comb begin
    div_m1_s = DIV0_M1;
    case (sel_r)
      2'b00:   div_m1_s = DIV0_M1;
      2'b01:   div_m1_s = DIV1_M1;
      2'b10:   div_m1_s = DIV2_M1;
      2'b11:   div_m1_s = DIV3_M1;
      default: div_m1_s = DIV0_M1;
    endcase
  end

  // Prescaler next state; a rate change always wins so the new period starts from zero.
  always_comb begin
    presc_nxt_s = presc_r;
    tick_s      = 1'b0;
    if (sel_chg_s) begin
      presc_nxt_s = {PRESC_W{1'b0}};
    end else if (!bus.SW2) begin
      presc_nxt_s = presc_r;
    end else if (presc_r == div_m1_s) begin
      presc_nxt_s = {PRESC_W{1'b0}};
      tick_s      = 1'b1;
    end else begin
      presc_nxt_s = presc_r + PRESC_W'(1);
    end
  end

  // Counter next state; the terminal check precedes the step so WIDTH-bit arithmetic never overflows.
  always_comb begin
    count_nxt_s = count_r;
    wrap_nxt_s  = 1'b0;
    if (!tick_s) begin
      count_nxt_s = count_r;
    end else if (!bus.SW1) begin
      if (count_r == MAX_C) begin
        count_nxt_s = {WIDTH{1'b0}};
        wrap_nxt_s  = 1'b1;
      end else begin
        count_nxt_s = count_r + WIDTH'(1);
      end
    end else begin
      if (count_r == {WIDTH{1'b0}}) begin
        count_nxt_s = MAX_C;
        wrap_nxt_s  = 1'b1;
      end else begin
        count_nxt_s = count_r - WIDTH'(1);
      end
    end
  end

  // State and output registers, cleared asynchronously by SW0.
  always_ff @(posedge PIN_Y2 or posedge SW0) begin
    if (SW0) begin
      sel_r   <= 2'b00;
      presc_r <= {PRESC_W{1'b0}};
      count_r <= {WIDTH{1'b0}};
      tick_r  <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      sel_r   <= sel_in_s;
      presc_r <= presc_nxt_s;
      count_r <= count_nxt_s;
      tick_r  <= tick_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

  assign bus.count = count_r;
  assign bus.tick  = tick_r;
  assign bus.wrap  = wrap_r;

endmodule

// File: tb/tb_rate_mod_counter.sv
// Directed bench for rate_mod_counter with short dividers (DIV0=4, DIV1=2, DIV2=5, DIV3=1).
// Expected {count,tick,wrap} values are worked out by hand for each step.
module tb_rate_mod_counter;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   c;

  rate_mod_counter_if #(.WIDTH(4)) bus ();

  rate_mod_counter #(
    .WIDTH(4), .MAX_COUNT(7), .PRESC_W(29),
    .DIV0(4), .DIV1(2), .DIV2(5), .DIV3(1)
  ) dut (
    .PIN_Y2 (clk),
    .SW0    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] ec, input logic et, input logic ew);
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {bus.count, bus.tick, bus.wrap};
    exp = {ec, et, ew};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed count=%0d tick=%b wrap=%b, expected count=%0d tick=%b wrap=%b",
             tag, obs[5:2], obs[1], obs[0], ec, et, ew);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n edges with no tick, count held at cv
  task automatic idle(input string tag, input int n, input int cv);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, 4'(cv), 1'b0, 1'b0);
    end
  endtask

  // n edges where only the last one ticks, moving count from cb to ca
  task automatic run_to_tick(input string tag, input int n, input int cb, input int ca, input logic w);
    if (n > 1) idle(tag, n - 1, cb);
    step();
    chk(tag, 4'(ca), 1'b1, w);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.SW17 = 1'b0;
    bus.SW16 = 1'b0;
    bus.SW1  = 1'b0;
    bus.SW2  = 1'b1;

    step();
    step();
    chk("reset", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Up count at DIV0=4: tick every 4th edge, wrap on 7->0
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("up", 4'((k / 4) % 8), (k % 4) == 0, k == 32);
    end

    // Down count from 0 wraps to 7
    bus.SW1 = 1'b1;
    run_to_tick("down_wrap", 4, 0, 7, 1'b1);
    run_to_tick("down", 4, 7, 6, 1'b0);
    run_to_tick("down", 4, 6, 5, 1'b0);
    // Direction flipped mid-period takes effect on the next tick
    idle("dir_mid", 2, 5);
    bus.SW1 = 1'b0;
    run_to_tick("dir_up", 2, 5, 6, 1'b0);

    // Rate change with prescaler at 2: 5 clocks after the change edge, then every 5
    idle("pre_chg", 2, 6);
    bus.SW17 = 1'b1;
    bus.SW16 = 1'b0;
    run_to_tick("rate_chg", 6, 6, 7, 1'b0);
    run_to_tick("rate_div5", 5, 7, 0, 1'b1);

    // Back to DIV0, prescaler parked at 1, then pause 10 cycles
    bus.SW17 = 1'b0;
    idle("sel_back", 2, 0);
    bus.SW2 = 1'b0;
    idle("pause", 10, 0);
    bus.SW2 = 1'b1;
    run_to_tick("resume", 3, 0, 1, 1'b0);

    // Rate change and pause together: prescaler clears, no tick
    bus.SW16 = 1'b1;
    bus.SW2  = 1'b0;
    idle("chg_pause", 3, 1);
    bus.SW2 = 1'b1;
    run_to_tick("div2_after", 2, 1, 2, 1'b0);

    // DIV3=1: change edge has no tick, then a tick every cycle
    bus.SW17 = 1'b1;
    bus.SW16 = 1'b1;
    idle("div1_chg", 1, 2);
    c = 2;
    for (int k = 0; k < 11; k++) begin
      run_to_tick("div1", 1, c, (c + 1) % 8, c == 7);
      c = (c + 1) % 8;
    end
    chk("div1_at5", 4'd5, 1'b1, 1'b0);

    // Async reset between edges while tick is high
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst", 4'd0, 1'b0, 1'b0);
    idle("rst_hold", 3, 0);
    rst = 1'b0;
    idle("post_rst_chg", 1, 0);
    run_to_tick("post_rst", 1, 0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rate_mod_counter.md
Name: rate_mod_counter

Overview:
Parametrised successor to the board's switch-selected slow counter. One clock domain; an internal prescaler generates a single-cycle tick at one of four selectable rates, and a WIDTH-bit modulo counter advances on each tick, up or down, with pause and a wrap flag. No derived clocks: all state runs on PIN_Y2, and the tick is used only as an enable. Outputs drive LEDs/7-seg decoders on the board or feed other counters.

Parameters:
WIDTH, 4, counter width in bits
MAX_COUNT, 7, terminal count; counter range 0..MAX_COUNT; must be < 2**WIDTH
PRESC_W, 29, prescaler width
DIV0, 25000000, tick period in clocks for rate select 00
DIV1, 50000000, tick period for select 01
DIV2, 100000000, tick period for select 10
DIV3, 300000000, tick period for select 11; every DIVn must satisfy 1 <= DIVn < 2**PRESC_W

Ports:
PIN_Y2  input  1  system clock, rising edge
SW0  input  1  reset, asynchronous, active-high
SW17  input  1  rate select MSB
SW16  input  1  rate select LSB
SW1  input  1  direction: 0 = up, 1 = down
SW2  input  1  enable: 1 = run, 0 = pause
count  output  WIDTH  current count value
tick  output  1  one-cycle pulse, high in the cycle count updates
wrap  output  1  one-cycle pulse, high when the update wrapped

Behaviour:
- Reset (SW0 high, asynchronous): count=0, tick=0, wrap=0, prescaler=0, registered select=00. All remain held while SW0 is high. First prescaler increment occurs on the first rising edge after SW0 falls.
- Inputs SW17/SW16/SW1/SW2 are sampled directly each edge. Board-level synchronisers are outside this block.
- Rate select {SW17,SW16} is registered each cycle as sel_q. When {SW17,SW16} != sel_q, the prescaler clears to 0 on that edge and no tick is issued. The new period then starts cleanly from 0.
- Prescaler, when SW2=1 and select is unchanged:
  - If prescaler == DIV(sel_q)-1: clear to 0 and assert the tick condition.
  - Else: increment by 1.
  - Tick period is exactly DIVn clocks. With DIVn=1, tick fires every enabled cycle.
- Pause (SW2=0): prescaler holds its value, no tick, count holds. Resuming continues from the held phase.
- Count update on the tick condition, applied at the same edge:
  - Up: count==MAX_COUNT -> 0 with wrap=1; otherwise count+1.
  - Down: count==0 -> MAX_COUNT with wrap=1; otherwise count-1.
  - Direction is sampled at the tick edge, so a direction change takes effect on the next tick. No extra step or skip occurs.
- tick and wrap are registered outputs. Each is high for exactly one cycle, coincident with the new count value, and low in every other cycle.
- Count never leaves 0..MAX_COUNT. Intermediate arithmetic is WIDTH bits; no overflow is possible because wrap is detected before incrementing.
- A rate change and a pause in the same cycle: prescaler clears to 0, no tick.
- Reset asserted mid-period or mid-pulse: all outputs go to reset values immediately, without waiting for a clock.
- Latency: from the last prescaler edge of a period, count, tick and wrap update at that same edge, with zero added pipeline.

Test Plan:
Simulation overrides: WIDTH=4, MAX_COUNT=7, DIV0=4, DIV1=2, DIV2=5, DIV3=1.
- Reset/basic up count: SW0 pulsed high, select 00, SW2=1, SW1=0 -> count 0 until the first tick at the 4th edge after release; count goes 1,2,...,7,0 every 4 clocks; wrap high only on the 7->0 cycle; tick high exactly 1 of every 4 cycles.
- Down count and direction change: SW1=1 from count=0 -> next tick gives 7 with wrap=1, then 6,5. Set SW1=0 mid-period -> next tick gives 6, with no skipped value.
- Rate change resync: select 00, prescaler at 2; switch to 10 -> no tick on the change edge; next tick exactly 5 clocks after the change edge, then every 5.
- Pause: SW2=0 for 10 cycles with prescaler at 1 -> count, tick and wrap frozen. SW2=1 -> tick after 3 more clocks (phase preserved).
- DIV=1 corner: select 11 -> tick high continuously; count increments every cycle; wrap every 8th cycle.
- Async reset mid-operation: assert SW0 between clock edges at count=5 with tick high -> count=0, tick=0, wrap=0 immediately, before the next edge. Hold 3 cycles -> values unchanged.
